// File: rtl/memory_access_stage.sv
// Memory-access pipeline stage: one data-memory load/store per instruction over req/ack,
// registered hand-off to RW. Optional misaligned-access trap under MA_ALIGN_CHECK_EN.
module memory_access_stage #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       input_MA_PC,
  input  logic [31:0]       input_MA_ALU_Result,
  input  logic [31:0]       input_MA_op2,
  input  logic [31:0]       input_MA_IR,
  input  logic [21:0]       input_MA_controlBus,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       output_MA_PC,
  output logic [31:0]       output_MA_ALU_Result,
  output logic [31:0]       output_MA_LD_Result,
  output logic [31:0]       output_MA_IR,
  output logic [21:0]       output_MA_controlBus,
  output logic              MA_stall,
  output logic [15:0]       MA_stall_count,
  output logic              MA_misaligned
);

  localparam int unsigned ST_BIT = 8;
  localparam int unsigned LD_BIT = 7;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state;
  logic [31:0] pc_q;
  logic [31:0] alu_q;
  logic [31:0] ir_q;
  logic [21:0] ctrl_q;

  logic is_st;
  logic is_ld;
  logic is_mem;
  logic misalign;
  logic accept;

  assign is_st  = input_MA_controlBus[ST_BIT];
  assign is_ld  = input_MA_controlBus[LD_BIT];
  assign is_mem = is_st | is_ld;

`ifdef MA_ALIGN_CHECK_EN
  assign misalign = is_mem && (input_MA_ALU_Result[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign MA_stall = (state == ACCESS);

  always_ff @(posedge clk) begin
    if (reset) begin
      state                <= IDLE;
      pc_q                 <= '0;
      alu_q                <= '0;
      ir_q                 <= '0;
      ctrl_q               <= '0;
      dmem_req             <= 1'b0;
      dmem_we              <= 1'b0;
      dmem_addr            <= '0;
      dmem_wdata           <= '0;
      out_valid            <= 1'b0;
      output_MA_PC         <= '0;
      output_MA_ALU_Result <= '0;
      output_MA_LD_Result  <= '0;
      output_MA_IR         <= '0;
      output_MA_controlBus <= '0;
      MA_stall_count       <= '0;
      MA_misaligned        <= 1'b0;
    end else begin
      MA_misaligned <= 1'b0;
      if (state == IDLE) begin
        if (accept) begin
          if (is_mem && !misalign) begin
            // Hold the instruction aside so the RW-side register keeps its forwarding value
            pc_q       <= input_MA_PC;
            alu_q      <= input_MA_ALU_Result;
            ir_q       <= input_MA_IR;
            ctrl_q     <= input_MA_controlBus;
            dmem_req   <= 1'b1;
            dmem_we    <= is_st;
            dmem_addr  <= input_MA_ALU_Result[ADDR_W-1:0];
            dmem_wdata <= input_MA_op2;
            out_valid  <= 1'b0;
            state      <= ACCESS;
          end else begin
            output_MA_PC         <= input_MA_PC;
            output_MA_ALU_Result <= input_MA_ALU_Result;
            output_MA_LD_Result  <= '0;
            output_MA_IR         <= input_MA_IR;
            output_MA_controlBus <= input_MA_controlBus;
            out_valid            <= 1'b1;
            MA_misaligned        <= misalign;
          end
        end else begin
          out_valid <= out_valid && !out_ready;
        end
      end else begin
        if (MA_stall_count != 16'hFFFF) begin
          MA_stall_count <= MA_stall_count + 16'd1;
        end
        if (dmem_ack) begin
          // A store with the load bit also set is a store: no load data returned
          dmem_req             <= 1'b0;
          output_MA_PC         <= pc_q;
          output_MA_ALU_Result <= alu_q;
          output_MA_LD_Result  <= (ctrl_q[LD_BIT] && !ctrl_q[ST_BIT]) ? dmem_rdata : 32'd0;
          output_MA_IR         <= ir_q;
          output_MA_controlBus <= ctrl_q;
          out_valid            <= 1'b1;
          state                <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// Self-checking bench for memory_access_stage: directed scenarios plus randomized traffic
// against a transaction-level model (queue of expected RW hand-offs).
module tb_memory_access_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc, in_alu, in_op2, in_ir;
  logic [21:0] in_ctrl;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        out_valid, out_ready;
  logic [31:0] o_pc, o_alu, o_ld, o_ir;
  logic [21:0] o_ctrl;
  logic        ma_stall;
  logic [15:0] ma_stall_count;
  logic        ma_misaligned;

  memory_access_stage #(.ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .input_MA_PC(in_pc), .input_MA_ALU_Result(in_alu), .input_MA_op2(in_op2),
    .input_MA_IR(in_ir), .input_MA_controlBus(in_ctrl),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .output_MA_PC(o_pc), .output_MA_ALU_Result(o_alu), .output_MA_LD_Result(o_ld),
    .output_MA_IR(o_ir), .output_MA_controlBus(o_ctrl),
    .MA_stall(ma_stall), .MA_stall_count(ma_stall_count), .MA_misaligned(ma_misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] op2;
    logic [31:0] ir;
    logic [31:0] ld;
    logic [21:0] ctrl;
  } rec_t;

  rec_t m_q[$];
  rec_t m_rec;
  bit   m_pending;
  bit   m_mis;
  int   m_cnt;
  int   wait_cnt;
  int   total;
  int   bad;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_instr(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] op2,
                           input logic [31:0] ir, input logic [21:0] ctrl);
    in_pc = pc; in_alu = alu; in_op2 = op2; in_ir = ir; in_ctrl = ctrl;
  endtask

  // One clock: inputs already driven at the falling edge; model advances across the rising edge
  task automatic tick();
    bit   acc, cons, mem, mis;
    rec_t r;
    #1;
    check_eq("in_ready", 32'(in_ready), 32'(!m_pending && (m_q.size() == 0 || out_ready)));
    acc  = in_valid && !m_pending && (m_q.size() == 0 || out_ready);
    cons = (m_q.size() != 0) && out_ready;
    if (cons) begin
      check_eq("out_pc",   o_pc,          m_q[0].pc);
      check_eq("out_alu",  o_alu,         m_q[0].alu);
      check_eq("out_ld",   o_ld,          m_q[0].ld);
      check_eq("out_ir",   o_ir,          m_q[0].ir);
      check_eq("out_ctrl", 32'(o_ctrl),   32'(m_q[0].ctrl));
    end
    if (reset) begin
      m_q.delete();
      m_pending = 0;
      m_mis     = 0;
      m_cnt     = 0;
    end else begin
      if (m_pending) begin
        if (m_cnt < 65535) m_cnt++;
        if (dmem_ack) begin
          m_rec.ld = (m_rec.ctrl[7] && !m_rec.ctrl[8]) ? dmem_rdata : 32'd0;
          m_q.push_back(m_rec);
          m_pending = 0;
        end
      end
      m_mis = 0;
      if (cons) void'(m_q.pop_front());
      if (acc) begin
        r.pc = in_pc; r.alu = in_alu; r.op2 = in_op2; r.ir = in_ir; r.ctrl = in_ctrl; r.ld = '0;
        mem = in_ctrl[7] || in_ctrl[8];
`ifdef MA_ALIGN_CHECK_EN
        mis = mem && (in_alu[1:0] != 2'b00);
`else
        mis = 0;
`endif
        if (mem && !mis) begin
          m_rec     = r;
          m_pending = 1;
          wait_cnt  = int'($urandom_range(0, 4));
        end else begin
          m_q.push_back(r);
          m_mis = mis;
        end
      end
    end
    @(negedge clk);
    check_eq("out_valid",   32'(out_valid),      32'(m_q.size() != 0));
    check_eq("dmem_req",    32'(dmem_req),       32'(m_pending));
    check_eq("ma_stall",    32'(ma_stall),       32'(m_pending));
    check_eq("stall_count", 32'(ma_stall_count), 32'(m_cnt));
    check_eq("misaligned",  32'(ma_misaligned),  32'(m_mis));
    if (m_pending) begin
      check_eq("dmem_we",    32'(dmem_we), 32'(m_rec.ctrl[8]));
      check_eq("dmem_addr",  dmem_addr,    m_rec.alu);
      check_eq("dmem_wdata", dmem_wdata,   m_rec.op2);
    end
  endtask

  initial begin
    total = 0; bad = 0; m_pending = 0; m_mis = 0; m_cnt = 0; wait_cnt = 0;
    reset = 1; in_valid = 0; out_ready = 0; dmem_ack = 0; dmem_rdata = '0;
    set_instr('0, '0, '0, '0, '0);
    @(negedge clk);
    tick();
    reset = 0;
    tick();
    check_eq("rst_pc",    o_pc,               32'd0);
    check_eq("rst_alu",   o_alu,              32'd0);
    check_eq("rst_ld",    o_ld,               32'd0);
    check_eq("rst_addr",  dmem_addr,          32'd0);
    check_eq("rst_wdata", dmem_wdata,         32'd0);
    check_eq("rst_we",    32'(dmem_we),       32'd0);

    // Stray ack with no request outstanding
    dmem_ack = 1; dmem_rdata = 32'hBAD0_BAD0;
    tick();
    dmem_ack = 0;
    tick();

    // ALU op then back-to-back ALU ops
    out_ready = 1; in_valid = 1;
    set_instr(32'h100, 32'h0000_0010, 32'h5, 32'h13, 22'h000003);
    tick();
    check_eq("alu_out", o_alu, 32'h10);
    check_eq("alu_ld",  o_ld,  32'h0);
    for (int i = 1; i < 4; i++) begin
      set_instr(32'h100 + 32'(4 * i), 32'(i * 16), 32'h5, 32'h13, 22'h000001);
      tick();
      check_eq("b2b_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 0;
    tick();

    // Load with three wait cycles
    reset = 1; tick(); reset = 0;
    in_valid = 1; set_instr(32'h200, 32'h40, 32'h0, 32'h03, 22'h000080);
    tick();
    in_valid = 0;
    for (int i = 0; i < 3; i++) tick();
    dmem_ack = 1; dmem_rdata = 32'hDEADBEEF;
    tick();
    dmem_ack = 0;
    check_eq("ld_result",   o_ld,                32'hDEADBEEF);
    check_eq("ld_stallcnt", 32'(ma_stall_count), 32'd4);
    tick();

    // Store with RW back-pressure
    out_ready = 0; in_valid = 1;
    set_instr(32'h300, 32'h80, 32'h1234, 32'h23, 22'h000100);
    tick();
    in_valid = 0;
    check_eq("st_wdata", dmem_wdata, 32'h1234);
    dmem_ack = 1; dmem_rdata = 32'hFFFF_FFFF;
    tick();
    dmem_ack = 0;
    for (int i = 0; i < 2; i++) tick();
    check_eq("st_ld",    o_ld,              32'd0);
    check_eq("st_ready", 32'(in_ready),     32'd0);
    out_ready = 1;
    tick();

    // Reset in the middle of an access; a late ack must be ignored
    in_valid = 1; set_instr(32'h400, 32'h44, 32'h0, 32'h03, 22'h000080);
    tick();
    in_valid = 0; reset = 1;
    tick();
    reset = 0;
    check_eq("rst_acc_req",   32'(dmem_req),  32'd0);
    check_eq("rst_acc_valid", 32'(out_valid), 32'd0);
    dmem_ack = 1;
    tick();
    dmem_ack = 0;
    tick();

`ifdef MA_ALIGN_CHECK_EN
    in_valid = 1; set_instr(32'h500, 32'h42, 32'h0, 32'h03, 22'h000080);
    tick();
    in_valid = 0;
    check_eq("mis_pulse", 32'(ma_misaligned), 32'd1);
    check_eq("mis_req",   32'(dmem_req),      32'd0);
    check_eq("mis_ld",    o_ld,               32'd0);
    tick();
    check_eq("mis_clear", 32'(ma_misaligned), 32'd0);
`endif

    // Randomized traffic with a random-latency responder and stray acks
    for (int c = 0; c < 3000; c++) begin
      reset     = ($urandom_range(0, 199) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      set_instr($urandom, ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC),
                $urandom, $urandom, 22'($urandom));
      dmem_rdata = $urandom;
      if (m_pending) begin
        dmem_ack = (wait_cnt == 0);
        if (wait_cnt > 0) wait_cnt--;
      end else begin
        dmem_ack = ($urandom_range(0, 4) == 0);
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
